// File: rtl/map_renderer_pkg.sv
// Shared game definitions: map geometry, cell codes and the display palette.
// Imported by the renderer and by the snake/fruit writers of the map RAM.
package map_renderer_pkg;

    localparam int BLOCK_SIZE = 10;
    localparam int MAP_W      = 64;
    localparam int MAP_H      = 48;
    localparam int BLINK_LOG2 = 3;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int AXIS_W   = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BODY  = 2'd1,
        HEAD  = 2'd2,
        FRUIT = 2'd3
    } cell_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t PAL_EMPTY      = '{r: 8'h10, g: 8'h10, b: 8'h10};
    localparam rgb_t PAL_BODY       = '{r: 8'h00, g: 8'hC0, b: 8'h00};
    localparam rgb_t PAL_HEAD       = '{r: 8'h00, g: 8'hFF, b: 8'h80};
    localparam rgb_t PAL_FRUIT      = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t PAL_DEAD       = '{r: 8'h80, g: 8'h00, b: 8'h00};
    localparam rgb_t PAL_FRUIT_DEAD = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

    // Game-over recolours the snake and freezes the fruit on, ignoring blink.
    function automatic rgb_t cell_colour(input cell_e code, input logic game_over,
                                         input logic blink_on);
        rgb_t c;
        c = PAL_EMPTY;
        case (code)
            BODY:    c = game_over ? PAL_DEAD : PAL_BODY;
            HEAD:    c = game_over ? PAL_DEAD : PAL_HEAD;
            FRUIT:   c = game_over ? PAL_FRUIT_DEAD : (blink_on ? PAL_FRUIT : PAL_EMPTY);
            default: c = PAL_EMPTY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/map_renderer_if.sv
// Pixel/map-RAM/colour bus between the VGA timing block, map RAM and renderer.
interface map_renderer_if;
    logic        pix_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        game_over;
    logic [11:0] rd_addr;
    logic [1:0]  rd_data;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;

    modport master (output pix_en, x, y, game_over, rd_data, input rd_addr, R, G, B);
    modport slave  (input pix_en, x, y, game_over, rd_data, output rd_addr, R, G, B);
endinterface

// File: rtl/map_renderer_cell_counter.sv
// One screen axis: pixel-in-cell counter plus cell index, divider-free.
// Exposes the next-state index so the caller can register it in the same cycle.
module cell_counter #(
    parameter int SUB_MAX = 10,
    parameter int IDX_MAX = 64,
    parameter int SUB_W   = $clog2(SUB_MAX),
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_d_o
);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // NOTE: defaults first so no path through this block leaves a value unassigned (no latch).
    always_comb begin
        sub_d = sub_q;
        idx_d = idx_q;
        if (clr_i) begin
            sub_d = '0;
            idx_d = '0;
        end else if (inc_i) begin
            if (sub_q == SUB_W'(SUB_MAX - 1)) begin
                sub_d = '0;
                idx_d = (idx_q == IDX_W'(IDX_MAX - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= '0;
            idx_q <= '0;
        end else begin
            sub_q <= sub_d;
            idx_q <= idx_d;
        end
    end

    assign idx_d_o = idx_d;

endmodule

// File: rtl/map_renderer.sv
// Read-side map renderer: pixel position -> map RAM address -> palette colour,
// two-stage pipeline (address register, colour register) with fruit blinking.
module map_renderer #(
    parameter int BLOCK_SIZE = map_renderer_pkg::BLOCK_SIZE,
    parameter int MAP_W      = map_renderer_pkg::MAP_W,
    parameter int MAP_H      = map_renderer_pkg::MAP_H,
    parameter int BLINK_LOG2 = map_renderer_pkg::BLINK_LOG2
) (
    input logic           CLOCK_50,
    input logic           reset,
    map_renderer_if.slave vga
);
    import map_renderer_pkg::*;

    logic              in_range, x_zero, y_zero;
    logic [AXIS_W-1:0] bx_d, by_d;

    logic [11:0]         rd_addr_q, rd_addr_d;
    logic [BLINK_LOG2:0] frame_cnt_q, frame_cnt_d;
    logic                v1_q, oob1_q, blink1_q;
    rgb_t                rgb_q, rgb_d;

    assign x_zero   = (vga.x == '0);
    assign y_zero   = (vga.y == '0);
    assign in_range = vga.pix_en && (vga.x < 10'(H_ACTIVE)) && (vga.y < 10'(V_ACTIVE));

    cell_counter #(.SUB_MAX(BLOCK_SIZE), .IDX_MAX(MAP_W), .IDX_W(AXIS_W)) u_x_axis (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .clr_i   (in_range && x_zero),
        .inc_i   (in_range && !x_zero),
        .idx_d_o (bx_d)
    );

    // The y axis only advances at the start of each visible line.
    cell_counter #(.SUB_MAX(BLOCK_SIZE), .IDX_MAX(MAP_H), .IDX_W(AXIS_W)) u_y_axis (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .clr_i   (in_range && x_zero && y_zero),
        .inc_i   (in_range && x_zero && !y_zero),
        .idx_d_o (by_d)
    );

    always_comb begin
        rd_addr_d   = rd_addr_q;
        frame_cnt_d = frame_cnt_q;
        if (in_range) rd_addr_d = {by_d, bx_d};
        if (vga.pix_en && x_zero && y_zero) frame_cnt_d = frame_cnt_q + 1'b1;
    end

    // Blink phase comes from the frame count before this strobe's increment.
    always_comb begin
        rgb_d = rgb_q;
        if (v1_q) rgb_d = oob1_q ? '0 : cell_colour(cell_e'(vga.rd_data), vga.game_over, blink1_q);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            rd_addr_q   <= '0;
            frame_cnt_q <= '0;
            v1_q        <= 1'b0;
            oob1_q      <= 1'b0;
            blink1_q    <= 1'b0;
            rgb_q       <= '0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            frame_cnt_q <= frame_cnt_d;
            v1_q        <= vga.pix_en;
            oob1_q      <= !in_range;
            blink1_q    <= ~frame_cnt_q[BLINK_LOG2];
            rgb_q       <= rgb_d;
        end
    end

    assign vga.rd_addr = rd_addr_q;
    assign vga.R       = rgb_q.r;
    assign vga.G       = rgb_q.g;
    assign vga.B       = rgb_q.b;

endmodule
